// File: rtl/dispatcher_mc_pkg.sv
// rtl/dispatcher_mc_pkg.sv - shared worker-result / packet-request definitions for dispatcher_mc
// Worker result layout (MSB first): dest_option[2:0], dest_addr[7:0], color[3:0], data[31:0].
// Packet request layout (MSB first): dest_option, dest_addr, color, data, extra[31:0].
package dispatcher_mc_pkg;

  localparam int DEST_OPTION_WIDTH    = 3;
  localparam int DEST_ADDR_WIDTH      = 8;
  localparam int COLOR_WIDTH          = 4;
  localparam int DATA_WIDTH           = 32;
  localparam int EXTRA_WIDTH          = 32;
  localparam int WORKER_RESULT_WIDTH  = DEST_OPTION_WIDTH + DEST_ADDR_WIDTH + COLOR_WIDTH + DATA_WIDTH;
  localparam int PACKET_REQUEST_WIDTH = WORKER_RESULT_WIDTH + EXTRA_WIDTH;

  // Field positions inside a worker result; dest option occupies the top bits.
  localparam int DEST_OPTION_LSB = WORKER_RESULT_WIDTH - DEST_OPTION_WIDTH;
  localparam int DEST_ADDR_LSB   = DEST_OPTION_LSB - DEST_ADDR_WIDTH;
  localparam int COLOR_LSB       = DEST_ADDR_LSB - COLOR_WIDTH;
  localparam int DATA_LSB        = 0;

  typedef logic [DEST_OPTION_WIDTH-1:0] dest_option_t;

  localparam dest_option_t DEST_OPTION_EXEC  = 3'd0;
  localparam dest_option_t DEST_OPTION_ONE   = 3'd1;
  localparam dest_option_t DEST_OPTION_LEFT  = 3'd2;
  localparam dest_option_t DEST_OPTION_RIGHT = 3'd3;
  localparam dest_option_t DEST_OPTION_END   = 3'd4;

  function automatic dest_option_t wr_dest_option(input logic [WORKER_RESULT_WIDTH-1:0] wr);
    return wr[DEST_OPTION_LSB +: DEST_OPTION_WIDTH];
  endfunction

  function automatic logic [DEST_ADDR_WIDTH-1:0] wr_dest_addr(input logic [WORKER_RESULT_WIDTH-1:0] wr);
    return wr[DEST_ADDR_LSB +: DEST_ADDR_WIDTH];
  endfunction

  function automatic logic [COLOR_WIDTH-1:0] wr_color(input logic [WORKER_RESULT_WIDTH-1:0] wr);
    return wr[COLOR_LSB +: COLOR_WIDTH];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] wr_data(input logic [WORKER_RESULT_WIDTH-1:0] wr);
    return wr[DATA_LSB +: DATA_WIDTH];
  endfunction

  function automatic logic targets_pr(input dest_option_t opt);
    return (opt == DEST_OPTION_EXEC) || (opt == DEST_OPTION_ONE);
  endfunction

  function automatic logic targets_wr(input dest_option_t opt);
    return (opt == DEST_OPTION_LEFT) || (opt == DEST_OPTION_RIGHT);
  endfunction

  function automatic logic [PACKET_REQUEST_WIDTH-1:0] make_packet_request(
    input dest_option_t                 dest_option,
    input logic [DEST_ADDR_WIDTH-1:0]   dest_addr,
    input logic [COLOR_WIDTH-1:0]       color,
    input logic [DATA_WIDTH-1:0]        data,
    input logic [EXTRA_WIDTH-1:0]       extra
  );
    return {dest_option, dest_addr, color, data, extra};
  endfunction

endpackage

// File: rtl/dispatcher_fifo.sv
// rtl/dispatcher_fifo.sv - registered output queue used by dispatcher_mc
// Ports: CLK, RST (sync active-high); push/push_data write side (ignored when full);
// pop read side (ignored when empty); full, count occupancy; valid/head expose the oldest entry.
module dispatcher_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     valid,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // No bypass: a full queue refuses a push even if it is popped on the same edge.
  assign full    = (count == CW'(DEPTH));
  assign valid   = (count != '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/dispatcher_mc.sv
// rtl/dispatcher_mc.sv - multi-lane round-robin dispatcher of worker results
// Ports: CLK, RST (sync active-high); RECEIVE_WR_* NUM_PORTS input lanes (valid/data/ready);
// SEND_WR_* worker results to matching_memory; SEND_PR_* packet requests to packet_loader;
// EXECUTION_END one-cycle pulse per END result.
// Option DISPATCHER_MC_DROP_COUNT_EN: adds saturating DROP_COUNT (unknown dest) and END_COUNT.
module dispatcher_mc
  import dispatcher_mc_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  output logic                                     EXECUTION_END,
  input  logic [NUM_PORTS-1:0]                     RECEIVE_WR_VALID,
  input  logic [NUM_PORTS*WORKER_RESULT_WIDTH-1:0] RECEIVE_WR_DATA,
  output logic [NUM_PORTS-1:0]                     RECEIVE_WR_READY,
  output logic                                     SEND_WR_VALID,
  output logic [WORKER_RESULT_WIDTH-1:0]           SEND_WR_DATA,
  input  logic                                     SEND_WR_READY,
  output logic                                     SEND_PR_VALID,
  output logic [PACKET_REQUEST_WIDTH-1:0]          SEND_PR_DATA,
  input  logic                                     SEND_PR_READY
`ifdef DISPATCHER_MC_DROP_COUNT_EN
  ,
  output logic [15:0]                              DROP_COUNT,
  output logic [15:0]                              END_COUNT
`endif
);

  localparam int W     = WORKER_RESULT_WIDTH;
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [W-1:0]                    lane_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]            eligible;
  logic                            grant_found;
  logic [PTR_W-1:0]                grant_idx;
  logic [PTR_W-1:0]                rr_ptr;
  logic [PTR_W-1:0]                rr_next;
  logic [W-1:0]                    grant_data;
  dest_option_t                    grant_opt;
  logic                            accept;
  logic                            pr_push;
  logic                            wr_push;
  logic [PACKET_REQUEST_WIDTH-1:0] pr_push_data;
  logic                            pr_full;
  logic                            wr_full;
  logic [CNT_W-1:0]                pr_count;
  logic [CNT_W-1:0]                wr_count;

  // A lane may only be granted if its target queue has room now (registered count).
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      lane_data[i] = RECEIVE_WR_DATA[i*W +: W];
      if (targets_pr(wr_dest_option(lane_data[i]))) begin
        eligible[i] = RECEIVE_WR_VALID[i] && (pr_count < CNT_W'(FIFO_DEPTH));
      end else if (targets_wr(wr_dest_option(lane_data[i]))) begin
        eligible[i] = RECEIVE_WR_VALID[i] && (wr_count < CNT_W'(FIFO_DEPTH));
      end else begin
        eligible[i] = RECEIVE_WR_VALID[i];
      end
    end
  end

  // First eligible lane at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_PORTS;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    accept           = grant_found && !RST;
    RECEIVE_WR_READY = '0;
    if (accept) begin
      RECEIVE_WR_READY[grant_idx] = 1'b1;
    end
    grant_data   = lane_data[grant_idx];
    grant_opt    = wr_dest_option(grant_data);
    pr_push      = accept && targets_pr(grant_opt) && !pr_full;
    wr_push      = accept && targets_wr(grant_opt) && !wr_full;
    pr_push_data = make_packet_request(grant_opt, wr_dest_addr(grant_data), wr_color(grant_data),
                                       wr_data(grant_data), 32'b0);
    rr_next      = (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + PTR_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr        <= '0;
      EXECUTION_END <= 1'b0;
    end else begin
      if (accept) rr_ptr <= rr_next;
      EXECUTION_END <= accept && (grant_opt == DEST_OPTION_END);
    end
  end

`ifdef DISPATCHER_MC_DROP_COUNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      DROP_COUNT <= '0;
      END_COUNT  <= '0;
    end else if (accept) begin
      if (grant_opt == DEST_OPTION_END) begin
        if (END_COUNT != 16'hFFFF) END_COUNT <= END_COUNT + 16'd1;
      end else if (!targets_pr(grant_opt) && !targets_wr(grant_opt)) begin
        if (DROP_COUNT != 16'hFFFF) DROP_COUNT <= DROP_COUNT + 16'd1;
      end
    end
  end
`endif

  dispatcher_fifo #(
    .WIDTH (PACKET_REQUEST_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_pr_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (pr_push),
    .push_data (pr_push_data),
    .pop       (SEND_PR_READY),
    .full      (pr_full),
    .count     (pr_count),
    .valid     (SEND_PR_VALID),
    .head      (SEND_PR_DATA)
  );

  dispatcher_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (wr_push),
    .push_data (grant_data),
    .pop       (SEND_WR_READY),
    .full      (wr_full),
    .count     (wr_count),
    .valid     (SEND_WR_VALID),
    .head      (SEND_WR_DATA)
  );

endmodule

// File: tb/tb_dispatcher_mc.sv
// tb/tb_dispatcher_mc.sv - directed self-checking bench for dispatcher_mc
module tb_dispatcher_mc;

  localparam int W  = 47;
  localparam int PW = 79;
  localparam logic [2:0] O_EXEC  = 3'd0;
  localparam logic [2:0] O_ONE   = 3'd1;
  localparam logic [2:0] O_LEFT  = 3'd2;
  localparam logic [2:0] O_RIGHT = 3'd3;
  localparam logic [2:0] O_END   = 3'd4;
  localparam logic [2:0] O_BAD   = 3'd7;

  logic          CLK = 1'b0;
  logic          RST;
  logic          EXECUTION_END;
  logic [3:0]    RECEIVE_WR_VALID;
  logic [4*W-1:0] RECEIVE_WR_DATA;
  logic [3:0]    RECEIVE_WR_READY;
  logic          SEND_WR_VALID;
  logic [W-1:0]  SEND_WR_DATA;
  logic          SEND_WR_READY;
  logic          SEND_PR_VALID;
  logic [PW-1:0] SEND_PR_DATA;
  logic          SEND_PR_READY;
`ifdef DISPATCHER_MC_DROP_COUNT_EN
  logic [15:0]   DROP_COUNT;
  logic [15:0]   END_COUNT;
`endif

  int errors = 0;
  int checks = 0;

  dispatcher_mc #(.NUM_PORTS(4), .FIFO_DEPTH(4)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .EXECUTION_END    (EXECUTION_END),
    .RECEIVE_WR_VALID (RECEIVE_WR_VALID),
    .RECEIVE_WR_DATA  (RECEIVE_WR_DATA),
    .RECEIVE_WR_READY (RECEIVE_WR_READY),
    .SEND_WR_VALID    (SEND_WR_VALID),
    .SEND_WR_DATA     (SEND_WR_DATA),
    .SEND_WR_READY    (SEND_WR_READY),
    .SEND_PR_VALID    (SEND_PR_VALID),
    .SEND_PR_DATA     (SEND_PR_DATA),
    .SEND_PR_READY    (SEND_PR_READY)
`ifdef DISPATCHER_MC_DROP_COUNT_EN
    ,
    .DROP_COUNT       (DROP_COUNT),
    .END_COUNT        (END_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input logic [2:0] o, input logic [7:0] a,
                                      input logic [3:0] c, input logic [31:0] d);
    return {o, a, c, d};
  endfunction

  function automatic logic [PW-1:0] pr_of(input logic [W-1:0] w);
    return {w, 32'h0};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_lane(input int i, input logic v, input logic [W-1:0] w);
    RECEIVE_WR_VALID[i]       = v;
    RECEIVE_WR_DATA[i*W +: W] = w;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    RECEIVE_WR_VALID = '0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    SEND_WR_READY = 1'b1;
    SEND_PR_READY = 1'b1;
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, mk(O_EXEC, 8'(i), 4'h0, 32'h0));
    #1;
    checks++; if (RECEIVE_WR_READY !== 4'b0000) begin errors++; $display("FAIL rst_ready_in_reset: got %b expected 0000", RECEIVE_WR_READY); end
    tick();
    checks++; if (EXECUTION_END !== 1'b0) begin errors++; $display("FAIL rst_exec_end: got %b expected 0", EXECUTION_END); end
    checks++; if (SEND_WR_VALID !== 1'b0) begin errors++; $display("FAIL rst_wr_valid: got %b expected 0", SEND_WR_VALID); end
    checks++; if (SEND_PR_VALID !== 1'b0) begin errors++; $display("FAIL rst_pr_valid: got %b expected 0", SEND_PR_VALID); end
    checks++; if (RECEIVE_WR_READY !== 4'b0000) begin errors++; $display("FAIL rst_ready_held: got %b expected 0000", RECEIVE_WR_READY); end
`ifdef DISPATCHER_MC_DROP_COUNT_EN
    checks++; if (DROP_COUNT !== 16'd0) begin errors++; $display("FAIL rst_drop_count: got %0d expected 0", DROP_COUNT); end
    checks++; if (END_COUNT !== 16'd0) begin errors++; $display("FAIL rst_end_count: got %0d expected 0", END_COUNT); end
`endif
    RST = 1'b0;
    RECEIVE_WR_VALID = '0;
  endtask

  task automatic test_single_lane;
    logic [W-1:0] w;
    do_reset();
    SEND_WR_READY = 1'b1;
    SEND_PR_READY = 1'b1;
    w = mk(O_LEFT, 8'h5A, 4'h3, 32'hDEAD_BEEF);
    set_lane(0, 1'b1, w);
    #1;
    checks++; if (RECEIVE_WR_READY !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", RECEIVE_WR_READY); end
    tick();
    set_lane(0, 1'b0, w);
    checks++; if (SEND_WR_VALID !== 1'b1) begin errors++; $display("FAIL single_wr_valid: got %b expected 1", SEND_WR_VALID); end
    checks++; if (SEND_WR_DATA !== w) begin errors++; $display("FAIL single_wr_data: got %h expected %h", SEND_WR_DATA, w); end
    checks++; if (SEND_PR_VALID !== 1'b0) begin errors++; $display("FAIL single_pr_quiet: got %b expected 0", SEND_PR_VALID); end
    tick();
    checks++; if (SEND_WR_VALID !== 1'b0) begin errors++; $display("FAIL single_wr_drained: got %b expected 0", SEND_WR_VALID); end
  endtask

  task automatic test_fairness;
    logic [W-1:0] cur [4];
    logic [W-1:0] prev;
    int round [4];
    int g;
    do_reset();
    SEND_WR_READY = 1'b1;
    SEND_PR_READY = 1'b1;
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      round[i] = 0;
      cur[i] = mk((i % 2) ? O_ONE : O_EXEC, 8'(i), 4'h0, 32'hA000_0000 + 32'(i * 256));
      set_lane(i, 1'b1, cur[i]);
    end
    #1;
    for (int t = 0; t < 8; t++) begin
      g = t % 4;
      checks++; if (RECEIVE_WR_READY !== (4'b0001 << g)) begin errors++; $display("FAIL fair_grant[%0d]: got %b expected %b", t, RECEIVE_WR_READY, 4'b0001 << g); end
      if (t > 0) begin
        checks++; if (SEND_PR_VALID !== 1'b1 || SEND_PR_DATA !== pr_of(prev)) begin errors++; $display("FAIL fair_pr[%0d]: got v=%b %h expected v=1 %h", t, SEND_PR_VALID, SEND_PR_DATA, pr_of(prev)); end
      end
      prev = cur[g];
      tick();
      round[g]++;
      cur[g] = mk((g % 2) ? O_ONE : O_EXEC, 8'(g), 4'(round[g]), 32'hA000_0000 + 32'(g * 256 + round[g]));
      set_lane(g, 1'b1, cur[g]);
      #1;
    end
    RECEIVE_WR_VALID = '0;
    checks++; if (SEND_PR_DATA !== pr_of(prev)) begin errors++; $display("FAIL fair_pr_last: got %h expected %h", SEND_PR_DATA, pr_of(prev)); end
  endtask

  task automatic test_back_pressure;
    logic [W-1:0] b [5];
    do_reset();
    SEND_PR_READY = 1'b0;
    SEND_WR_READY = 1'b1;
    for (int i = 0; i < 5; i++) b[i] = mk(O_EXEC, 8'(8'h10 + i), 4'h0, 32'hB000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, b[i]);
    #1;
    for (int t = 0; t < 4; t++) begin
      checks++; if (RECEIVE_WR_READY !== (4'b0001 << t)) begin errors++; $display("FAIL bp_grant[%0d]: got %b expected %b", t, RECEIVE_WR_READY, 4'b0001 << t); end
      tick();
      if (t == 0) set_lane(0, 1'b1, b[4]);
      else set_lane(t, 1'b0, b[t]);
      #1;
    end
    checks++; if (RECEIVE_WR_READY !== 4'b0000) begin errors++; $display("FAIL bp_full_ready: got %b expected 0000", RECEIVE_WR_READY); end
    checks++; if (SEND_PR_VALID !== 1'b1 || SEND_PR_DATA !== pr_of(b[0])) begin errors++; $display("FAIL bp_head: got v=%b %h expected v=1 %h", SEND_PR_VALID, SEND_PR_DATA, pr_of(b[0])); end
    tick();
    checks++; if (RECEIVE_WR_READY !== 4'b0000) begin errors++; $display("FAIL bp_full_hold: got %b expected 0000", RECEIVE_WR_READY); end
    SEND_PR_READY = 1'b1;
    tick();
    SEND_PR_READY = 1'b0;
    #1;
    checks++; if (RECEIVE_WR_READY !== 4'b0001) begin errors++; $display("FAIL bp_fifth_ready: got %b expected 0001", RECEIVE_WR_READY); end
    tick();
    set_lane(0, 1'b0, b[4]);
    SEND_PR_READY = 1'b1;
    for (int j = 1; j < 5; j++) begin
      checks++; if (SEND_PR_VALID !== 1'b1 || SEND_PR_DATA !== pr_of(b[j])) begin errors++; $display("FAIL bp_drain[%0d]: got v=%b %h expected v=1 %h", j, SEND_PR_VALID, SEND_PR_DATA, pr_of(b[j])); end
      tick();
    end
    checks++; if (SEND_PR_VALID !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", SEND_PR_VALID); end
  endtask

  task automatic test_concurrent_drain;
    logic [W-1:0] c [5];
    logic [W-1:0] r;
    do_reset();
    SEND_PR_READY = 1'b0;
    SEND_WR_READY = 1'b1;
    for (int i = 0; i < 5; i++) c[i] = mk(O_ONE, 8'(8'h20 + i), 4'h1, 32'hC000_0000 + 32'(i));
    r = mk(O_RIGHT, 8'h77, 4'h2, 32'h1234_5678);
    set_lane(2, 1'b1, c[0]);
    #1;
    for (int j = 0; j < 4; j++) begin
      checks++; if (RECEIVE_WR_READY !== 4'b0100) begin errors++; $display("FAIL cc_fill[%0d]: got %b expected 0100", j, RECEIVE_WR_READY); end
      tick();
      set_lane(2, 1'b1, c[j+1]);
      #1;
    end
    set_lane(1, 1'b1, r);
    #1;
    checks++; if (RECEIVE_WR_READY !== 4'b0010) begin errors++; $display("FAIL cc_wr_not_blocked: got %b expected 0010", RECEIVE_WR_READY); end
    tick();
    set_lane(1, 1'b0, r);
    SEND_PR_READY = 1'b1;
    #1;
    checks++; if (SEND_WR_VALID !== 1'b1 || SEND_WR_DATA !== r) begin errors++; $display("FAIL cc_wr_out: got v=%b %h expected v=1 %h", SEND_WR_VALID, SEND_WR_DATA, r); end
    checks++; if (SEND_PR_DATA !== pr_of(c[0])) begin errors++; $display("FAIL cc_pr_head: got %h expected %h", SEND_PR_DATA, pr_of(c[0])); end
    checks++; if (RECEIVE_WR_READY !== 4'b0000) begin errors++; $display("FAIL cc_no_bypass: got %b expected 0000", RECEIVE_WR_READY); end
    tick();
    checks++; if (SEND_WR_VALID !== 1'b0) begin errors++; $display("FAIL cc_wr_popped: got %b expected 0", SEND_WR_VALID); end
    checks++; if (SEND_PR_DATA !== pr_of(c[1])) begin errors++; $display("FAIL cc_pr_popped: got %h expected %h", SEND_PR_DATA, pr_of(c[1])); end
    checks++; if (RECEIVE_WR_READY !== 4'b0100) begin errors++; $display("FAIL cc_room_again: got %b expected 0100", RECEIVE_WR_READY); end
    tick();
    set_lane(2, 1'b0, c[4]);
    for (int j = 2; j < 5; j++) begin
      checks++; if (SEND_PR_VALID !== 1'b1 || SEND_PR_DATA !== pr_of(c[j])) begin errors++; $display("FAIL cc_drain[%0d]: got v=%b %h expected v=1 %h", j, SEND_PR_VALID, SEND_PR_DATA, pr_of(c[j])); end
      tick();
    end
    checks++; if (SEND_PR_VALID !== 1'b0) begin errors++; $display("FAIL cc_empty: got %b expected 0", SEND_PR_VALID); end
  endtask

  task automatic test_end;
    do_reset();
    SEND_PR_READY = 1'b1;
    SEND_WR_READY = 1'b1;
    set_lane(3, 1'b1, mk(O_END, 8'h00, 4'h0, 32'h0));
    #1;
    checks++; if (RECEIVE_WR_READY !== 4'b1000) begin errors++; $display("FAIL end_ready: got %b expected 1000", RECEIVE_WR_READY); end
    tick();
    set_lane(3, 1'b0, '0);
    checks++; if (EXECUTION_END !== 1'b1) begin errors++; $display("FAIL end_pulse: got %b expected 1", EXECUTION_END); end
    checks++; if (SEND_WR_VALID !== 1'b0 || SEND_PR_VALID !== 1'b0) begin errors++; $display("FAIL end_no_push: got wr=%b pr=%b expected 0 0", SEND_WR_VALID, SEND_PR_VALID); end
`ifdef DISPATCHER_MC_DROP_COUNT_EN
    checks++; if (DROP_COUNT !== 16'd0) begin errors++; $display("FAIL drop_before: got %0d expected 0", DROP_COUNT); end
`endif
    tick();
    checks++; if (EXECUTION_END !== 1'b0) begin errors++; $display("FAIL end_one_cycle: got %b expected 0", EXECUTION_END); end
    set_lane(0, 1'b1, mk(O_BAD, 8'h33, 4'h4, 32'h5555_AAAA));
    #1;
    checks++; if (RECEIVE_WR_READY !== 4'b0001) begin errors++; $display("FAIL unk_ready: got %b expected 0001", RECEIVE_WR_READY); end
    tick();
    set_lane(0, 1'b0, '0);
    checks++; if (EXECUTION_END !== 1'b0) begin errors++; $display("FAIL unk_no_end: got %b expected 0", EXECUTION_END); end
    checks++; if (SEND_WR_VALID !== 1'b0 || SEND_PR_VALID !== 1'b0) begin errors++; $display("FAIL unk_no_push: got wr=%b pr=%b expected 0 0", SEND_WR_VALID, SEND_PR_VALID); end
`ifdef DISPATCHER_MC_DROP_COUNT_EN
    checks++; if (DROP_COUNT !== 16'd1) begin errors++; $display("FAIL drop_after: got %0d expected 1", DROP_COUNT); end
    checks++; if (END_COUNT !== 16'd1) begin errors++; $display("FAIL end_count: got %0d expected 1", END_COUNT); end
`endif
  endtask

  task automatic test_reset_mid_flight;
    do_reset();
    SEND_PR_READY = 1'b0;
    SEND_WR_READY = 1'b0;
    set_lane(0, 1'b1, mk(O_LEFT, 8'h01, 4'h0, 32'h0000_0001));
    set_lane(1, 1'b1, mk(O_EXEC, 8'h02, 4'h0, 32'h0000_0002));
    set_lane(2, 1'b1, mk(O_EXEC, 8'h03, 4'h0, 32'h0000_0003));
    #1;
    for (int t = 0; t < 3; t++) begin
      checks++; if (RECEIVE_WR_READY !== (4'b0001 << t)) begin errors++; $display("FAIL mid_grant[%0d]: got %b expected %b", t, RECEIVE_WR_READY, 4'b0001 << t); end
      tick();
      set_lane(t, 1'b0, '0);
      #1;
    end
    checks++; if (SEND_WR_VALID !== 1'b1 || SEND_PR_VALID !== 1'b1) begin errors++; $display("FAIL mid_queued: got wr=%b pr=%b expected 1 1", SEND_WR_VALID, SEND_PR_VALID); end
    RST = 1'b1;
    set_lane(1, 1'b1, mk(O_EXEC, 8'h11, 4'h0, 32'h0000_0011));
    set_lane(3, 1'b1, mk(O_EXEC, 8'h13, 4'h0, 32'h0000_0013));
    #1;
    checks++; if (RECEIVE_WR_READY !== 4'b0000) begin errors++; $display("FAIL mid_ready_in_reset: got %b expected 0000", RECEIVE_WR_READY); end
    tick();
    RST = 1'b0;
    #1;
    checks++; if (SEND_WR_VALID !== 1'b0 || SEND_PR_VALID !== 1'b0) begin errors++; $display("FAIL mid_flushed: got wr=%b pr=%b expected 0 0", SEND_WR_VALID, SEND_PR_VALID); end
    checks++; if (RECEIVE_WR_READY !== 4'b0010) begin errors++; $display("FAIL mid_rr_restart: got %b expected 0010", RECEIVE_WR_READY); end
    RECEIVE_WR_VALID = '0;
  endtask

  initial begin
    RST              = 1'b1;
    RECEIVE_WR_VALID = '0;
    RECEIVE_WR_DATA  = '0;
    SEND_WR_READY    = 1'b0;
    SEND_PR_READY    = 1'b0;
    test_reset();
    test_single_lane();
    test_fairness();
    test_back_pressure();
    test_concurrent_drain();
    test_end();
    test_reset_mid_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dispatcher_mc.md
Name: dispatcher_mc

Overview:
- Multi-channel successor of the single-input dispatcher.
- Accepts worker results from NUM_PORTS worker lanes through a round-robin arbiter and classifies each one by its 3-bit dest option (top bits of the word):
  - EXEC/ONE results become packet requests for packet_loader.
  - LEFT/RIGHT results are forwarded to matching_memory.
  - END raises EXECUTION_END.
- Each output has its own FIFO, so both outputs drain concurrently and there is no single-transaction stall.

Parameters:
- NUM_PORTS, 4, number of worker-result input lanes (1..16).
- FIFO_DEPTH, 4, entries per output FIFO (power of two, >=2).
- WORKER_RESULT_WIDTH, codebase value, width of one worker result.
- PACKET_REQUEST_WIDTH, codebase value, width of one packet request.

Ports:
- CLK  in  1  clock, all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EXECUTION_END  out  1  one-cycle pulse per accepted END result.
- RECEIVE_WR_VALID  in  NUM_PORTS  per-lane valid.
- RECEIVE_WR_DATA  in  NUM_PORTS*WORKER_RESULT_WIDTH  lane i occupies slice [i*W +: W].
- RECEIVE_WR_READY  out  NUM_PORTS  per-lane ready, one-hot or zero.
- SEND_WR_VALID  out  1  WR FIFO not empty.
- SEND_WR_DATA  out  WORKER_RESULT_WIDTH  WR FIFO head.
- SEND_WR_READY  in  1  matching_memory accepts.
- SEND_PR_VALID  out  1  PR FIFO not empty.
- SEND_PR_DATA  out  PACKET_REQUEST_WIDTH  PR FIFO head.
- SEND_PR_READY  in  1  packet_loader accepts.

Behaviour:
- Transfer rule: a transfer happens when VALID and READY are both high on a rising edge. A sender holds VALID and DATA until the transfer.
- Lane eligibility:
  - A lane is eligible when its VALID is high and its target has room.
  - Target is PR FIFO for EXEC/ONE and WR FIFO for LEFT/RIGHT; room means count < FIFO_DEPTH.
  - END and unknown options have no target and are always eligible.
- Arbitration and ready:
  - Round-robin pointer rr_ptr: pick the first eligible lane starting at rr_ptr, ascending and wrapping.
  - At most one lane is accepted per cycle.
  - RECEIVE_WR_READY is combinational: only the granted lane's bit is high, and all bits are 0 when no lane is eligible.
  - On a grant to lane g, rr_ptr <= (g+1) mod NUM_PORTS. Otherwise rr_ptr holds.
- Push conversion:
  - EXEC/ONE results are converted with the shared make_packet_request(dest_option, dest_addr, color, data, 32'b0) before being pushed into the PR FIFO.
  - LEFT/RIGHT results are pushed into the WR FIFO unchanged.
- FIFOs:
  - Registered storage; output VALID = (count != 0); DATA = head entry.
  - Latency: a result accepted at edge t appears on the output after edge t, i.e. one cycle.
  - Full FIFO: push is blocked even when a pop happens on the same edge (no bypass). Eligibility uses the registered count only.
  - Empty FIFO: pop is impossible because VALID is low. Simultaneous push and pop on a non-full FIFO leaves count unchanged.
  - Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.
- EXECUTION_END is registered: it is 1 in the cycle after an accepted END result, otherwise 0.
- Unknown dest options are accepted and dropped without side effects.
- Reset:
  - Reset values: EXECUTION_END=0, SEND_WR_VALID=0, SEND_PR_VALID=0, rr_ptr=0, FIFO pointers and counts=0. RECEIVE_WR_READY is 0 while RST is high.
  - Reset mid-operation discards all queued entries. Stored data need not be cleared.

Optional Feature:
- DISPATCHER_MC_DROP_COUNT_EN defined:
  - Adds output DROP_COUNT[15:0], reset to 0.
  - Increments on each accepted unknown-dest result and saturates at 16'hFFFF.
  - Adds output END_COUNT[15:0] with the same reset and saturation rule, counting END results.
- Undefined: neither port nor counter exists, and unknown-dest results are silently dropped.

Decomposition:
- Shared package/include holds:
  - DEST_OPTION_* constants;
  - WORKER_RESULT_WIDTH and PACKET_REQUEST_WIDTH;
  - the dest-option field position;
  - make_packet_request and the worker_result field extractors.
- Natural sub-module: dispatcher_fifo (parameters WIDTH, DEPTH; push/pop/full/count interface), instantiated twice.
- Arbiter stays inline.

Test Plan:
- Single lane: lane 0 sends a LEFT result 0x… with SEND_WR_READY=1 -> SEND_WR_VALID=1 one cycle after acceptance with identical data, and SEND_PR_VALID stays 0.
- Fairness: all 4 lanes present EXEC continuously, both outputs always ready -> grants go 0,1,2,3,0,… one per cycle, and the PR output sequence matches the grant order.
- Back-pressure: SEND_PR_READY=0 and 5 EXEC results offered with FIFO_DEPTH=4 -> 4 accepted, the 5th lane's READY stays 0. Raising ready for 1 cycle -> the 5th is accepted on the following edge.
- Concurrent drain: lane 1 sends RIGHT while lane 2 sends ONE, both outputs ready -> both FIFOs pop in the same cycle, and a WR push is not blocked by a full PR FIFO.
- END: lane 3 sends END -> EXECUTION_END=1 for exactly one cycle and no FIFO push. With DISPATCHER_MC_DROP_COUNT_EN defined, dest option 3'b111 -> DROP_COUNT goes 0->1.
- Reset mid-flight: 3 entries queued, RST for 1 cycle -> both output VALIDs low next cycle, and rr_ptr restarts at lane 0.
